// File: rtl/frame_rx.sv
// Frame receiver behind the oversampling CDR: sync-word hunt, MSB-first payload
// deserialization, even-parity check, and link-up tracking with a watchdog.
module frame_rx #(
  parameter int unsigned DATA_W   = 8,
  parameter logic [7:0]  SYNC_PAT = 8'hD5,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic              i_clk,
  input  logic              i_res_n,
  input  logic              i_RecoveryData,
  input  logic              i_DataEn,
  input  logic              i_CdrErr,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_DataValid,
  output logic              o_FrameErr,
  output logic              o_LinkUp
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WD_W   = 16;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          sr_q, sr_d;
  logic [DATA_W-1:0]   pl_q, pl_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                link_q, link_d;

  logic [7:0]          sr_shift;
  logic                abort, par_bit_en, par_odd, frame_ok, frame_bad, expire;

  assign sr_shift   = {sr_q[6:0], i_RecoveryData};
  assign abort      = (state_q != HUNT) && i_CdrErr;
  assign par_bit_en = (state_q == PARITY) && i_DataEn && !i_CdrErr;
  assign par_odd    = ^{pl_q, i_RecoveryData};
  assign frame_ok   = par_bit_en && !par_odd;
  assign frame_bad  = abort || (par_bit_en && par_odd);
  assign expire     = link_q && (wd_q == '0);

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) state_q <= HUNT;
    else          state_q <= state_d;
  end

  // A CDR error anywhere inside a frame throws it away.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (i_DataEn && (sr_shift == SYNC_PAT)) state_d = PAYLOAD;
      PAYLOAD: begin
        if (i_CdrErr)                                       state_d = HUNT;
        else if (i_DataEn && (cnt_q == CNT_W'(DATA_W - 1))) state_d = PARITY;
      end
      PARITY:  if (i_CdrErr || i_DataEn) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    sr_d    = sr_q;
    pl_d    = pl_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = frame_bad;
    good_d  = good_q;
    wd_d    = wd_q;
    link_d  = link_q;

    if (i_DataEn) begin
      unique case (state_q)
        HUNT: begin
          sr_d = sr_shift;
          if (sr_shift == SYNC_PAT) begin
            pl_d  = '0;
            cnt_d = '0;
          end
        end
        PAYLOAD: if (!i_CdrErr) begin
          pl_d  = {pl_q[DATA_W-2:0], i_RecoveryData};
          cnt_d = cnt_q + CNT_W'(1);
        end
        PARITY:  if (!i_CdrErr) sr_d = '0;
        default: ;
      endcase
    end

    // A good frame wins over a simultaneous watchdog expiry.
    if (frame_ok) begin
      data_d  = pl_q;
      valid_d = 1'b1;
      good_d  = (good_q == GOOD_W'(LOCK_CNT)) ? good_q : good_q + GOOD_W'(1);
      wd_d    = WD_W'(TIMEOUT - 1);
      if (good_d == GOOD_W'(LOCK_CNT)) link_d = 1'b1;
    end else begin
      if (link_q && (wd_q != '0)) wd_d = wd_q - WD_W'(1);
      if (frame_bad || expire) begin
        good_d = '0;
        link_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      sr_q    <= '0;
      pl_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      good_q  <= '0;
      wd_q    <= '0;
      link_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      pl_q    <= pl_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      good_q  <= good_d;
      wd_q    <= wd_d;
      link_q  <= link_d;
    end
  end

  assign o_Data      = data_q;
  assign o_DataValid = valid_q;
  assign o_FrameErr  = err_q;
  assign o_LinkUp    = link_q;

endmodule

// File: tb/tb_frame_rx.sv
// Testbench for frame_rx: directed frame table, multi-cycle corner sequences and
// randomized traffic, all checked every cycle against a bit-queue reference model.
module tb_frame_rx;

  localparam int unsigned DW   = 8;
  localparam logic [7:0]  SYNC = 8'hD5;
  localparam int unsigned LOCK = 4;
  localparam int unsigned TO   = 200;

  logic          clk = 1'b0;
  logic          res_n, rec, en, cdr;
  logic [DW-1:0] data;
  logic          valid, ferr, link;

  always #5 clk = ~clk;

  frame_rx #(.DATA_W(DW), .SYNC_PAT(SYNC), .LOCK_CNT(LOCK), .TIMEOUT(TO)) dut (
    .i_clk          (clk),
    .i_res_n        (res_n),
    .i_RecoveryData (rec),
    .i_DataEn       (en),
    .i_CdrErr       (cdr),
    .o_Data         (data),
    .o_DataValid    (valid),
    .o_FrameErr     (ferr),
    .o_LinkUp       (link)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = hunting, 1 = collecting payload, 2 = awaiting parity.
  int            m_mode;
  logic [7:0]    m_sr;
  bit            m_bits[$];
  int            m_good, m_wd;
  bit            m_link, m_valid, m_err;
  logic [DW-1:0] m_data;

  int cyc_n, obs_valid, obs_err, valid_cyc, fall_cyc;
  bit link_at_valid, prev_link;

  typedef struct {
    logic [DW-1:0] payload;
    bit            flip;
    int            cdr_at;
    int            gap;
    bit            exp_valid;
    logic [DW-1:0] exp_data;
    bit            exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sr = '0; m_bits.delete();
    m_good = 0; m_wd = 0; m_link = 0; m_valid = 0; m_err = 0; m_data = '0;
  endtask

  task automatic model_step(input bit b, input bit e, input bit c);
    bit     expired, good, bad;
    longint value;
    int     ones;
    expired = m_link && (m_wd == 0);
    good = 0; bad = 0; value = 0; ones = 0;
    if (m_mode != 0 && c) begin
      bad = 1; m_mode = 0;
    end else if (e) begin
      if (m_mode == 0) begin
        m_sr = {m_sr[6:0], b};
        if (m_sr == SYNC) begin m_mode = 1; m_bits.delete(); end
      end else if (m_mode == 1) begin
        m_bits.push_back(b);
        if (m_bits.size() == int'(DW)) m_mode = 2;
      end else begin
        ones = int'(b);
        foreach (m_bits[i]) begin
          value = value * 2 + longint'(m_bits[i]);
          ones += int'(m_bits[i]);
        end
        if (ones % 2 == 0) good = 1; else bad = 1;
        m_mode = 0; m_sr = '0;
      end
    end
    m_valid = good; m_err = bad;
    if (good) begin
      m_data = DW'(value);
      m_good = (m_good < int'(LOCK)) ? m_good + 1 : int'(LOCK);
      m_wd   = int'(TO) - 1;
      if (m_good == int'(LOCK)) m_link = 1;
    end else begin
      if (m_link && m_wd > 0) m_wd--;
      if (bad || expired) begin m_good = 0; m_link = 0; end
    end
  endtask

  task automatic cmp_model();
    check("data", data, m_data);
    check("valid", valid, m_valid);
    check("frame_err", ferr, m_err);
    check("link_up", link, m_link);
    if (valid) begin obs_valid++; valid_cyc = cyc_n; link_at_valid = link; end
    if (ferr) obs_err++;
    if (prev_link && !link) fall_cyc = cyc_n;
    prev_link = link;
    cyc_n++;
  endtask

  task automatic cyc(input bit b, input bit e, input bit c);
    @(negedge clk);
    cmp_model();
    rec = b; en = e; cdr = c;
    model_step(b, e, c);
  endtask

  task automatic send_bit(input bit b, input bit c, input int gap);
    cyc(b, 1'b1, c);
    for (int i = 1; i < gap; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  // cdr_at = number of payload bits before the CDR error; DW puts it on the parity bit.
  task automatic send_frame(input logic [DW-1:0] p, input bit flip, input int cdr_at, input int gap);
    logic [7:0] s;
    bit         par;
    s = SYNC;
    for (int i = 7; i >= 0; i--) send_bit(s[i], 1'b0, gap);
    for (int i = int'(DW) - 1; i >= 0; i--) begin
      if (cdr_at == int'(DW) - 1 - i) begin
        cyc(1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        return;
      end
      send_bit(p[i], 1'b0, gap);
    end
    par = (^p) ^ flip;
    send_bit(par, cdr_at == int'(DW), gap);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset(input bit check_now);
    @(negedge clk);
    res_n = 1'b0; rec = 1'b0; en = 1'b0; cdr = 1'b0;
    #1;
    if (check_now) begin
      check("async_rst_data", data, 0);
      check("async_rst_valid", valid, 0);
      check("async_rst_err", ferr, 0);
      check("async_rst_link", link, 0);
    end
    model_reset();
    prev_link = 1'b0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] idle;
    res_n = 1'b0; rec = 1'b0; en = 1'b0; cdr = 1'b0;
    cyc_n = 0; obs_valid = 0; obs_err = 0; valid_cyc = 0; fall_cyc = -1;
    link_at_valid = 0; prev_link = 0;
    model_reset();

    vecs[0] = '{8'hA5, 1'b0, -1, 4, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h01, 1'b1, -1, 4, 1'b0, 8'hA5, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, -1, 1, 1'b1, 8'h3C, 1'b0};
    vecs[3] = '{8'hD5, 1'b0, -1, 2, 1'b1, 8'hD5, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, -1, 3, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h00, 1'b0, -1, 4, 1'b1, 8'h00, 1'b0};
    vecs[6] = '{8'h5A, 1'b0,  3, 4, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h77, 1'b0,  8, 2, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{8'h81, 1'b0, -1, 4, 1'b1, 8'h81, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    check("reset_data", data, 0);
    check("reset_valid", valid, 0);
    check("reset_err", ferr, 0);
    check("reset_link", link, 0);
    res_n = 1'b1;

    foreach (vecs[k]) begin
      obs_valid = 0; obs_err = 0;
      send_frame(vecs[k].payload, vecs[k].flip, vecs[k].cdr_at, vecs[k].gap);
      check($sformatf("vec%0d_valid_pulses", k), obs_valid, vecs[k].exp_valid);
      check($sformatf("vec%0d_err_pulses", k), obs_err, vecs[k].exp_err);
      check($sformatf("vec%0d_data", k), data, vecs[k].exp_data);
    end

    // Reset in the middle of a payload, then a clean frame.
    idle = SYNC;
    for (int i = 7; i >= 0; i--) send_bit(idle[i], 1'b0, 2);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 2);
    apply_reset(1'b1);
    obs_valid = 0;
    send_frame(8'h6B, 1'b0, -1, 4);
    check("post_reset_valid", obs_valid, 1);
    check("post_reset_data", data, 8'h6B);

    // Lock after LOCK good frames, then watchdog drop.
    apply_reset(1'b0);
    for (int f = 0; f < int'(LOCK); f++) begin
      link_at_valid = 0; obs_valid = 0;
      send_frame(DW'(8'h10 + f), 1'b0, -1, 4);
      check($sformatf("lock_valid%0d", f), obs_valid, 1);
      check($sformatf("lock_link_at_valid%0d", f), link_at_valid, f == int'(LOCK) - 1);
    end
    fall_cyc = -1;
    for (int i = 0; i < int'(TO) + 20 && fall_cyc < 0; i++) cyc(1'b0, 1'b0, 1'b0);
    check("timeout_fall_seen", fall_cyc >= 0, 1);
    check("timeout_latency", fall_cyc - valid_cyc, TO);

    // Relock, abort mid-payload, then recover.
    for (int f = 0; f < int'(LOCK); f++) send_frame(DW'(8'h20 + f), 1'b0, -1, 3);
    check("relock_link", link, 1);
    obs_valid = 0; obs_err = 0;
    send_frame(8'h5A, 1'b0, 3, 4);
    check("abort_err", obs_err, 1);
    check("abort_no_valid", obs_valid, 0);
    check("abort_link", link, 0);
    obs_valid = 0;
    send_frame(8'hC3, 1'b0, -1, 4);
    check("after_abort_valid", obs_valid, 1);
    check("after_abort_data", data, 8'hC3);

    // Idle 0xAA pattern ahead of the sync word.
    idle = 8'hAA;
    for (int j = 0; j < 3; j++)
      for (int i = 7; i >= 0; i--) send_bit(idle[i], 1'b0, 2);
    obs_valid = 0;
    send_frame(8'h96, 1'b0, -1, 2);
    check("idle_sync_valid", obs_valid, 1);
    check("idle_sync_data", data, 8'h96);

    // Randomized traffic against the model.
    for (int it = 0; it < 150; it++) begin
      int junk;
      junk = int'($urandom_range(0, 12));
      for (int j = 0; j < junk; j++)
        cyc(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 30) == 0);
      send_frame(DW'($urandom), $urandom_range(0, 4) == 0,
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DW)) : -1,
                 int'($urandom_range(1, 4)));
      if ($urandom_range(0, 24) == 0) repeat (int'(TO) + 10) cyc(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
